stcam_ctrl: RTL and testbench

//  Request sequencer for an array of STCAM cells (DEPTH rows x WIDTH bits).

---
 rtl/stcam_pkg.sv | 10 +
 rtl/stcam_prio_enc.sv | 19 +
 rtl/stcam_ctrl.sv | 101 ++++++++++
 tb/tb_stcam_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stcam_pkg.sv
// stcam_pkg: command encodings and controller states shared across the STCAM slice.
package stcam_pkg;
    typedef enum logic [1:0] {
        OP_SEARCH  = 2'b00,
        OP_WRITE   = 2'b01,
        OP_INV_ROW = 2'b10,
        OP_INV_ALL = 2'b11
    } op_e;
    typedef enum logic [2:0] {IDLE, WRITE, SEARCH, ENCODE, RESP} state_e;
endpackage

// File: rtl/stcam_prio_enc.sv
// stcam_prio_enc: lowest-index priority encoder with any-hit and multi-hit flags.
module stcam_prio_enc #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic [DEPTH-1:0] vec,
    output logic             hit,
    output logic [AW-1:0]    index,
    output logic             multi
);
    always_comb begin
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (vec[i]) index = AW'(i);
    end
    assign hit   = |vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - DEPTH'(1)));
endmodule

// File: rtl/stcam_ctrl.sv
// stcam_ctrl: write/search/invalidate sequencer for an STCAM array, with row-valid
// tracking and a lowest-index hit response.
module stcam_ctrl import stcam_pkg::*; #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int SEARCH_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_key,
    input  logic [WIDTH-1:0] req_mask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [AW-1:0]    rsp_index,
    output logic             rsp_multi,
    output logic [DEPTH-1:0] cam_we,
    output logic [WIDTH-1:0] cam_search_bit,
    output logic [WIDTH-1:0] cam_dont_care_bit,
    input  logic [DEPTH-1:0] cam_match_in
);
    localparam int CW = SEARCH_LAT > 1 ? $clog2(SEARCH_LAT) : 1;

    state_e           state, state_n;
    op_e              op;
    logic             accept, in_range, enc_hit, enc_multi;
    logic [AW-1:0]    addr_q, enc_index;
    logic [WIDTH-1:0] key_q, mask_q;
    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] row_valid, hit_vec, req_oh, addr_oh;

    assign op        = op_e'(req_op);
    assign accept    = req_valid && req_ready;
    assign in_range  = int'(req_addr) < DEPTH;
    assign req_oh    = in_range ? DEPTH'(1) << req_addr : '0;
    assign addr_oh   = DEPTH'(1) << addr_q;

    assign req_ready         = state == IDLE;
    assign rsp_valid         = state == RESP;
    assign cam_we            = state == WRITE ? addr_oh : '0;
    assign cam_search_bit    = (state == WRITE || state == SEARCH) ? key_q : '0;
    assign cam_dont_care_bit = state == WRITE ? mask_q : '0;

    stcam_prio_enc #(.DEPTH(DEPTH), .AW(AW)) u_enc (
        .vec(hit_vec), .hit(enc_hit), .index(enc_index), .multi(enc_multi)
    );

    // Out-of-range writes and all invalidates complete at the accept edge.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = op == OP_SEARCH ? SEARCH :
                                           (op == OP_WRITE && in_range) ? WRITE : IDLE;
            WRITE:   state_n = IDLE;
            SEARCH:  state_n = cnt == '0 ? ENCODE : SEARCH;
            ENCODE:  state_n = RESP;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_valid <= '0;
            hit_vec   <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            key_q     <= '0;
            mask_q    <= '0;
            rsp_hit   <= 1'b0;
            rsp_index <= '0;
            rsp_multi <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q <= req_addr;
                key_q  <= req_key;
                mask_q <= req_mask;
                cnt    <= CW'(SEARCH_LAT - 1);
                if (op == OP_INV_ROW) row_valid <= row_valid & ~req_oh;
                if (op == OP_INV_ALL) row_valid <= '0;
            end
            if (state == WRITE) row_valid <= row_valid | addr_oh;
            if (state == SEARCH) begin
                cnt <= cnt - CW'(1);
                if (cnt == '0) hit_vec <= cam_match_in & row_valid;
            end
            if (state == ENCODE) begin
                rsp_hit   <= enc_hit;
                rsp_index <= enc_index;
                rsp_multi <= enc_multi;
            end
        end
    end
endmodule

// File: tb/tb_stcam_ctrl.sv
// tb_stcam_ctrl: random and directed commands against a command-level CAM model,
// with a behavioural ternary array driving cam_match_in.
module tb_stcam_ctrl;
    import stcam_pkg::*;
    localparam int W = 8, D = 16, AW = 4, LAT = 1;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0, rsp_ready = 1'b0, d12_valid = 1'b0;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [W-1:0]  req_key = '0, req_mask = '0;
    logic          req_ready, rsp_valid, rsp_hit, rsp_multi;
    logic [AW-1:0] rsp_index;
    logic [D-1:0]  cam_we, cam_match_in;
    logic [W-1:0]  cam_search_bit, cam_dont_care_bit;
    logic          d12_ready, d12_rv, d12_hit, d12_multi;
    logic [AW-1:0] d12_index;
    logic [11:0]   d12_we;
    logic [W-1:0]  d12_sb, d12_dc;

    stcam_ctrl #(.WIDTH(W), .DEPTH(D), .AW(AW), .SEARCH_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_key(req_key), .req_mask(req_mask), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_index(rsp_index), .rsp_multi(rsp_multi),
        .cam_we(cam_we), .cam_search_bit(cam_search_bit), .cam_dont_care_bit(cam_dont_care_bit),
        .cam_match_in(cam_match_in)
    );

    stcam_ctrl #(.WIDTH(W), .DEPTH(12), .AW(AW), .SEARCH_LAT(LAT)) u_d12 (
        .clk(clk), .rst(rst), .req_valid(d12_valid), .req_ready(d12_ready), .req_op(req_op),
        .req_addr(req_addr), .req_key(req_key), .req_mask(req_mask), .rsp_valid(d12_rv),
        .rsp_ready(1'b1), .rsp_hit(d12_hit), .rsp_index(d12_index), .rsp_multi(d12_multi),
        .cam_we(d12_we), .cam_search_bit(d12_sb), .cam_dont_care_bit(d12_dc),
        .cam_match_in(12'h000)
    );

    // Array rows power up with garbage; odd rows are all don't-care and so always match.
    logic [W-1:0] arr_key [D];
    logic [W-1:0] arr_mask [D];
    always @(posedge clk)
        for (int r = 0; r < D; r++)
            if (rst) begin
                arr_key[r]  <= W'($urandom);
                arr_mask[r] <= r[0] ? '1 : W'($urandom) & W'($urandom);
            end else if (cam_we[r]) begin
                arr_key[r]  <= cam_search_bit;
                arr_mask[r] <= cam_dont_care_bit;
            end
    always_comb
        for (int r = 0; r < D; r++)
            cam_match_in[r] = ((cam_search_bit ^ arr_key[r]) & ~arr_mask[r]) == '0;

    bit           mv [D];
    logic [W-1:0] mk [D];
    logic [W-1:0] mm [D];
    logic          e_ready = 1'b1, e_rv = 1'b0, e_hit = 1'b0, e_multi = 1'b0;
    logic [AW-1:0] e_idx = '0;
    logic [D-1:0]  e_we = '0;
    logic [W-1:0]  e_sb = '0, e_dc = '0;
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (!rst) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("cam_we", 32'(cam_we), 32'(e_we));
            chk("search_bit", 32'(cam_search_bit), 32'(e_sb));
            chk("dont_care_bit", 32'(cam_dont_care_bit), 32'(e_dc));
            if (e_rv) begin
                chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
                chk("rsp_index", 32'(rsp_index), 32'(e_idx));
                chk("rsp_multi", 32'(rsp_multi), 32'(e_multi));
            end
            chk("d12_we", 32'(d12_we), 32'(0));
            chk("d12_idle", {26'd0, d12_ready, d12_rv, d12_hit, d12_multi, d12_index != '0,
                             (d12_sb | d12_dc) != '0}, 32'h20);
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_ready = 1'b1; e_rv = 1'b0; e_we = '0; e_sb = '0; e_dc = '0;
    endtask

    task automatic model_search(input logic [W-1:0] k, output logic h,
                                output logic [AW-1:0] idx, output logic m);
        int n = 0;
        idx = '0;
        for (int r = 0; r < D; r++)
            if (mv[r] && ((k ^ mk[r]) & ~mm[r]) == '0) begin
                if (n == 0) idx = AW'(r);
                n++;
            end
        h = n > 0;
        m = n > 1;
    endtask

    // Busy cycles keep req_valid high with an invalidate-all that must never be taken.
    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] key,
                          input logic [W-1:0] mask, input int rdly, output logic rh,
                          output logic [AW-1:0] ri, output logic rm);
        rh = 1'b0; ri = '0; rm = 1'b0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_key = key; req_mask = mask;
        rsp_ready = op == OP_SEARCH ? 1'b0 : 1'($urandom);
        idle_exp();
        step();
        req_op = OP_INV_ALL; req_addr = AW'($urandom); req_key = W'($urandom);
        if (op == OP_WRITE) begin
            e_ready = 1'b0; e_we = D'(1) << addr; e_sb = key; e_dc = mask;
            step();
            mv[addr] = 1'b1; mk[addr] = key; mm[addr] = mask;
        end else if (op == OP_INV_ROW) begin
            mv[addr] = 1'b0;
        end else if (op == OP_INV_ALL) begin
            for (int r = 0; r < D; r++) mv[r] = 1'b0;
        end else begin
            e_ready = 1'b0; e_sb = key;
            repeat (LAT) step();
            e_sb = '0;
            step();
            model_search(key, e_hit, e_idx, e_multi);
            e_rv = 1'b1;
            repeat (rdly) step();
            rsp_ready = 1'b1;
            rh = rsp_hit; ri = rsp_index; rm = rsp_multi;
            step();
            rsp_ready = 1'b0;
        end
        req_valid = 1'b0;
        idle_exp();
    endtask

    logic          h, m;
    logic [AW-1:0] ix;

    initial begin
        for (int r = 0; r < D; r++) mv[r] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("reset_ready", 32'(req_ready), 32'(1));
        chk("reset_rsp", {29'd0, rsp_valid, rsp_hit, rsp_multi}, 32'(0));
        chk("reset_index", 32'(rsp_index), 32'(0));
        chk("reset_cam", 32'(cam_we) | 32'(cam_search_bit) | 32'(cam_dont_care_bit), 32'(0));

        do_cmd(OP_SEARCH, 0, 8'h5A, 0, 0, h, ix, m);
        chk("empty_search", {h, m, 26'd0, ix}, 32'h0);
        do_cmd(OP_WRITE, 3, 8'h5A, 8'h00, 0, h, ix, m);
        do_cmd(OP_SEARCH, 0, 8'h5A, 0, 5, h, ix, m);
        chk("row3_search", {h, m, 26'd0, ix}, 32'h8000_0003);
        do_cmd(OP_WRITE, 2, 8'h50, 8'h0F, 0, h, ix, m);
        do_cmd(OP_SEARCH, 0, 8'h5A, 0, 1, h, ix, m);
        chk("row2_multi", {h, m, 26'd0, ix}, 32'hC000_0002);
        do_cmd(OP_INV_ROW, 2, 0, 0, 0, h, ix, m);
        do_cmd(OP_SEARCH, 0, 8'h5A, 0, 0, h, ix, m);
        chk("inv_row2", {h, m, 26'd0, ix}, 32'h8000_0003);
        do_cmd(OP_INV_ALL, 0, 0, 0, 0, h, ix, m);
        do_cmd(OP_SEARCH, 0, 8'h5A, 0, 2, h, ix, m);
        chk("inv_all", {h, m, 26'd0, ix}, 32'h0);

        req_op = OP_WRITE; req_addr = 4'd15; req_key = 8'hFF; req_mask = 8'h00; d12_valid = 1'b1;
        step();
        d12_valid = 1'b0;
        chk("d12_oob_ready", 32'(d12_ready), 32'(1));
        repeat (2) step();

        do_cmd(OP_WRITE, 3, 8'h5A, 8'h00, 0, h, ix, m);
        req_valid = 1'b1; req_op = OP_SEARCH; req_key = 8'h5A;
        step();
        req_valid = 1'b0; e_ready = 1'b0; e_sb = 8'h5A; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < D; r++) mv[r] = 1'b0;
        idle_exp();
        chk("midrst_ready", 32'(req_ready), 32'(1));
        chk("midrst_rsp", 32'(rsp_valid), 32'(0));
        step();
        do_cmd(OP_SEARCH, 0, 8'h5A, 0, 0, h, ix, m);
        chk("midrst_cleared", 32'(h), 32'(0));

        for (int n = 0; n < 250; n++) begin
            int sel;
            logic [1:0] op;
            logic [W-1:0] key, mask;
            logic [W-1:0] pool [4];
            pool[0] = 8'h5A; pool[1] = 8'h50; pool[2] = 8'hA5; pool[3] = 8'h3C;
            sel  = $urandom_range(0, 9);
            op   = sel < 4 ? OP_SEARCH : sel < 7 ? OP_WRITE : sel < 9 ? OP_INV_ROW : OP_INV_ALL;
            key  = pool[$urandom_range(0, 3)] ^ ($urandom_range(0, 3) == 0 ? W'($urandom) : '0);
            mask = $urandom_range(0, 2) == 0 ? W'($urandom) & W'($urandom) : '0;
            do_cmd(op, AW'($urandom), key, mask, $urandom_range(0, 3), h, ix, m);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
